// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern.
// One bit is consumed per clock while in_valid is high. A shift-register
// history is compared against the active pattern, and a fill counter
// prevents matches before enough bits have been seen. Overlapping or
// non-overlapping detection is chosen per consumed bit. A saturating
// counter tracks the number of detections.
module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // Fill counts 0..PAT_W, so it needs enough bits to hold PAT_W itself.
  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [FILL_W-1:0] r_fill;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_hist_next;
  logic             w_hit;
  logic             w_cnt_full;

  // Newest bit enters at the LSB, so the first-received bit of a complete
  // window ends up at the MSB and lines up with pattern[PAT_W-1]. A hit
  // needs PAT_W-1 previously valid bits plus the bit arriving now.
  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], in};
    w_hit       = in_valid && !load && (r_fill >= FILL_HIT) && (w_hist_next == r_pat);
    w_cnt_full  = &r_cnt;
  end

  // Pattern, history, fill level and registered match pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pat  <= DEFAULT_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else if (load) begin
      r_pat  <= pattern;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else if (in_valid) begin
      r_hist <= w_hist_next;
      r_out  <= w_hit;
      // Non-overlapping mode: the bits of a completed match are used up.
      if (w_hit && !overlap) begin
        r_fill <= '0;
      end else if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + 1'b1;
      end
    end else begin
      // Idle cycle: partial match is kept across gaps in in_valid.
      r_out <= 1'b0;
    end
  end

  // Saturating detection counter; a clear wins over a simultaneous hit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit && !w_cnt_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out       = r_out;
  assign match_cnt = r_cnt;
  assign cnt_sat   = w_cnt_full;

endmodule
